// File: rtl/c_boot_loader_if.sv
// rtl/c_boot_loader_if.sv - ROM read and memory write bus between the boot loader and its memories
// Ports (signals):
//   rom_addr_o  loader -> ROM   word address
//   rom_rd_o    loader -> ROM   read strobe, data returned on rom_data_i one cycle later
//   rom_data_i  ROM -> loader   read data
//   mem_addr_o  loader -> mem   write address
//   mem_wdata_o loader -> mem   write data
//   mem_we_o    loader -> mem   write request, held until mem_ack_i
//   mem_ack_i   mem -> loader   write accepted
interface c_boot_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rom_addr_o;
  logic              rom_rd_o;
  logic [DATA_W-1:0] rom_data_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_we_o;
  logic              mem_ack_i;

  modport master (
    output rom_addr_o, rom_rd_o,
    input  rom_data_i,
    output mem_addr_o, mem_wdata_o, mem_we_o,
    input  mem_ack_i
  );

  modport slave (
    input  rom_addr_o, rom_rd_o,
    output rom_data_i,
    input  mem_addr_o, mem_wdata_o, mem_we_o,
    output mem_ack_i
  );
endinterface

// File: rtl/c_boot_loader.sv
// rtl/c_boot_loader.sv - boot sequencer copying N_WORDS from boot ROM into processor memory
// Ports:
//   clk         in   system clock (same clock as c_clgen)
//   KEY         in   asynchronous active-low reset
//   start_i     in   start a copy (level, only looked at in IDLE)
//   reload_i    in   restart from DONE or ERR
//   bus         if   ROM read / memory write bus (master side)
//   load_done   out  copy complete and valid, feeds c_clgen
//   busy_o      out  copy in progress (RD, WAIT, WR, CHK)
//   error_o     out  checksum mismatch
//   checksum_o  out  running sum of copied words
module c_boot_loader #(
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 32,
  parameter int                N_WORDS    = 1024,
  parameter bit                CHECK_EN   = 1'b0,
  parameter logic [DATA_W-1:0] EXP_SUM    = '0,
  parameter bit                AUTO_START = 1'b1
) (
  input  logic                clk,
  input  logic                KEY,
  input  logic                start_i,
  input  logic                reload_i,
  c_boot_loader_if.master     bus,
  output logic                load_done,
  output logic                busy_o,
  output logic                error_o,
  output logic [DATA_W-1:0]   checksum_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  logic [2:0]        r_state;
  logic              r_auto;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rom_rd;
  logic              r_mem_we;
  logic              r_load_done;
  logic              r_busy;
  logic              r_error;

  logic [2:0]        w_nxt_state;
  logic              w_nxt_auto;
  logic [ADDR_W-1:0] w_nxt_addr;
  logic [DATA_W-1:0] w_nxt_sum;
  logic [DATA_W-1:0] w_nxt_wdata;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_auto  = r_auto;
    w_nxt_addr  = r_addr;
    w_nxt_sum   = r_sum;
    w_nxt_wdata = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (r_auto || start_i) begin
          w_nxt_auto  = 1'b0;
          w_nxt_addr  = '0;
          w_nxt_sum   = '0;
          w_nxt_state = S_RD;
        end
      end
      S_RD: w_nxt_state = S_WAIT;
      S_WAIT: begin
        // ROM data is valid in the cycle after the read strobe
        w_nxt_wdata = bus.rom_data_i;
        w_nxt_sum   = r_sum + bus.rom_data_i;
        w_nxt_state = S_WR;
      end
      S_WR: begin
        if (bus.mem_ack_i) begin
          if (r_addr == LAST_ADDR) begin
            w_nxt_state = S_CHK;
          end else begin
            w_nxt_addr  = r_addr + 1'b1;
            w_nxt_state = S_RD;
          end
        end
      end
      S_CHK: begin
        if (CHECK_EN && (r_sum != EXP_SUM)) w_nxt_state = S_ERR;
        else                                w_nxt_state = S_DONE;
      end
      S_DONE, S_ERR: begin
        // reload re-arms the auto-start flag so the next copy needs no start_i
        if (reload_i) begin
          w_nxt_auto  = 1'b1;
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every output is a flop
  // that is valid for exactly the cycles spent in the matching state.
  always_ff @(posedge clk or negedge KEY) begin
    if (!KEY) begin
      r_state     <= S_IDLE;
      r_auto      <= AUTO_START;
      r_addr      <= '0;
      r_sum       <= '0;
      r_wdata     <= '0;
      r_rom_rd    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_load_done <= 1'b0;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_auto      <= w_nxt_auto;
      r_addr      <= w_nxt_addr;
      r_sum       <= w_nxt_sum;
      r_wdata     <= w_nxt_wdata;
      r_rom_rd    <= (w_nxt_state == S_RD);
      r_mem_we    <= (w_nxt_state == S_WR);
      r_load_done <= (w_nxt_state == S_DONE);
      r_busy      <= (w_nxt_state == S_RD) || (w_nxt_state == S_WAIT) ||
                     (w_nxt_state == S_WR) || (w_nxt_state == S_CHK);
      r_error     <= (w_nxt_state == S_ERR);
    end
  end

  assign bus.rom_addr_o  = r_addr;
  assign bus.rom_rd_o    = r_rom_rd;
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_wdata_o = r_wdata;
  assign bus.mem_we_o    = r_mem_we;
  assign load_done       = r_load_done;
  assign busy_o          = r_busy;
  assign error_o         = r_error;
  assign checksum_o      = r_sum;

endmodule

// File: tb/tb_c_boot_loader.sv
// tb/tb_c_boot_loader.sv - directed self-checking bench for c_boot_loader
module tb_c_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic key = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic reload0 = 1'b0, reload1 = 1'b0, reload2 = 1'b0;
  logic ld0, ld1, ld2, busy0, busy1, busy2, err0, err1, err2;
  logic [31:0] cs0, cs1, cs2;

  c_boot_loader_if bus0 ();
  c_boot_loader_if bus1 ();
  c_boot_loader_if bus2 ();

  c_boot_loader #(.N_WORDS(4)) u0 (
    .clk(clk), .KEY(key), .start_i(start0), .reload_i(reload0), .bus(bus0),
    .load_done(ld0), .busy_o(busy0), .error_o(err0), .checksum_o(cs0));

  c_boot_loader #(.N_WORDS(4), .CHECK_EN(1'b1), .EXP_SUM(32'd11)) u1 (
    .clk(clk), .KEY(key), .start_i(start1), .reload_i(reload1), .bus(bus1),
    .load_done(ld1), .busy_o(busy1), .error_o(err1), .checksum_o(cs1));

  c_boot_loader #(.N_WORDS(4), .AUTO_START(1'b0)) u2 (
    .clk(clk), .KEY(key), .start_i(start2), .reload_i(reload2), .bus(bus2),
    .load_done(ld2), .busy_o(busy2), .error_o(err2), .checksum_o(cs2));

  logic [31:0] rom [4] = '{32'd1, 32'd2, 32'd3, 32'd4};

  always @(posedge clk) if (bus0.rom_rd_o) bus0.rom_data_i <= rom[bus0.rom_addr_o[1:0]];
  always @(posedge clk) if (bus1.rom_rd_o) bus1.rom_data_i <= rom[bus1.rom_addr_o[1:0]];
  always @(posedge clk) if (bus2.rom_rd_o) bus2.rom_data_i <= rom[bus2.rom_addr_o[1:0]];

  logic ack0 = 1'b1;
  assign bus0.mem_ack_i = ack0;
  assign bus1.mem_ack_i = 1'b1;
  assign bus2.mem_ack_i = 1'b1;

  // accepted-write logs
  logic [11:0] wa0 [$];
  logic [31:0] wd0 [$];
  int n_wr2 = 0;
  always @(posedge clk) begin
    if (bus0.mem_we_o && bus0.mem_ack_i) begin
      wa0.push_back(bus0.mem_addr_o);
      wd0.push_back(bus0.mem_wdata_o);
    end
    if (bus2.mem_we_o && bus2.mem_ack_i) n_wr2 = n_wr2 + 1;
  end

  int n_chk = 0;
  int n_fail = 0;
  int e = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_edge(input int target);
    while (e < target) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    key = 1'b0;
    @(negedge clk);
    key = 1'b1;
    e = 0;
  endtask

  task automatic chk_zero_u0(input string tag);
    chk({tag, " rom_addr"}, 32'(bus0.rom_addr_o), 32'd0);
    chk({tag, " rom_rd"}, 32'(bus0.rom_rd_o), 32'd0);
    chk({tag, " mem_addr"}, 32'(bus0.mem_addr_o), 32'd0);
    chk({tag, " mem_wdata"}, bus0.mem_wdata_o, 32'd0);
    chk({tag, " mem_we"}, 32'(bus0.mem_we_o), 32'd0);
    chk({tag, " load_done"}, 32'(ld0), 32'd0);
    chk({tag, " busy"}, 32'(busy0), 32'd0);
    chk({tag, " error"}, 32'(err0), 32'd0);
    chk({tag, " checksum"}, cs0, 32'd0);
  endtask

  initial begin
    int nb;
    int n2;
    #12;
    chk_zero_u0("reset");
    chk("reset u2 busy", 32'(busy2), 32'd0);

    // ---- copy, checksum error, AUTO_START=0, reload ----
    @(negedge clk);
    key = 1'b1;
    e = 0;
    to_edge(1);
    chk("t1 busy e1", 32'(busy0), 32'd1);
    chk("t1 rom_rd e1", 32'(bus0.rom_rd_o), 32'd1);
    chk("t1 rom_addr e1", 32'(bus0.rom_addr_o), 32'd0);
    chk("t6 idle busy e1", 32'(busy2), 32'd0);
    to_edge(2);
    chk("t1 rom_rd e2", 32'(bus0.rom_rd_o), 32'd0);
    to_edge(3);
    chk("t1 mem_we e3", 32'(bus0.mem_we_o), 32'd1);
    chk("t1 mem_addr e3", 32'(bus0.mem_addr_o), 32'd0);
    chk("t1 mem_wdata e3", bus0.mem_wdata_o, 32'd1);
    to_edge(4);
    chk("t1 mem_we e4", 32'(bus0.mem_we_o), 32'd0);
    chk("t1 rom_rd e4", 32'(bus0.rom_rd_o), 32'd1);
    chk("t1 rom_addr e4", 32'(bus0.rom_addr_o), 32'd1);
    chk("t6 still idle e4", 32'(busy2), 32'd0);
    start2 = 1'b1;
    to_edge(5);
    start2 = 1'b0;
    chk("t6 started e5", 32'(busy2), 32'd1);
    to_edge(7);
    start2 = 1'b1;
    to_edge(8);
    start2 = 1'b0;
    to_edge(13);
    chk("t1 load_done e13", 32'(ld0), 32'd0);
    chk("t3 error e13", 32'(err1), 32'd0);
    to_edge(14);
    chk("t1 load_done e14", 32'(ld0), 32'd1);
    chk("t1 checksum", cs0, 32'd10);
    chk("t1 busy e14", 32'(busy0), 32'd0);
    chk("t1 write count", 32'(wa0.size()), 32'd4);
    for (int i = 0; i < 4 && i < wa0.size(); i++) begin
      chk("t1 write addr", 32'(wa0[i]), 32'(i));
      chk("t1 write data", wd0[i], 32'(i + 1));
    end
    chk("t3 error e14", 32'(err1), 32'd1);
    chk("t3 load_done e14", 32'(ld1), 32'd0);
    chk("t3 checksum", cs1, 32'd10);
    reload0 = 1'b1;
    reload1 = 1'b1;
    start2  = 1'b1;
    to_edge(15);
    reload0 = 1'b0;
    reload1 = 1'b0;
    chk("t4 load_done drop e15", 32'(ld0), 32'd0);
    chk("t3 error clear e15", 32'(err1), 32'd0);
    to_edge(17);
    chk("t6 load_done e17", 32'(ld2), 32'd0);
    to_edge(18);
    chk("t6 load_done e18", 32'(ld2), 32'd1);
    to_edge(22);
    chk("t6 held start load_done", 32'(ld2), 32'd1);
    chk("t6 held start busy", 32'(busy2), 32'd0);
    chk("t6 write count", 32'(n_wr2), 32'd4);
    start2 = 1'b0;
    to_edge(20);
    chk("t3 rerun busy", 32'(busy1), 32'd1);
    to_edge(28);
    chk("t4 load_done e28", 32'(ld0), 32'd0);
    chk("t3 error e28", 32'(err1), 32'd0);
    to_edge(29);
    chk("t4 load_done e29", 32'(ld0), 32'd1);
    chk("t4 write count", 32'(wa0.size()), 32'd8);
    chk("t3 error e29", 32'(err1), 32'd1);

    // ---- stalled ack on word 2 ----
    release_reset();
    nb = wa0.size();
    to_edge(9);
    ack0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      to_edge(9 + i);
      chk("t2 stall mem_we", 32'(bus0.mem_we_o), 32'd1);
      chk("t2 stall addr", 32'(bus0.mem_addr_o), 32'd2);
      chk("t2 stall data", bus0.mem_wdata_o, 32'd3);
    end
    ack0 = 1'b1;
    to_edge(15);
    chk("t2 mem_we after ack", 32'(bus0.mem_we_o), 32'd0);
    to_edge(18);
    chk("t2 load_done e18", 32'(ld0), 32'd0);
    to_edge(19);
    chk("t2 load_done e19", 32'(ld0), 32'd1);
    chk("t2 write count", 32'(wa0.size() - nb), 32'd4);
    n2 = 0;
    for (int i = nb; i < wa0.size(); i++) if (wa0[i] == 12'd2) n2++;
    chk("t2 writes at addr2", 32'(n2), 32'd1);

    // ---- reset during a write ----
    release_reset();
    to_edge(9);
    chk("t5 mem_we before reset", 32'(bus0.mem_we_o), 32'd1);
    chk("t5 mem_addr before reset", 32'(bus0.mem_addr_o), 32'd2);
    #2;
    key = 1'b0;
    #1;
    chk_zero_u0("t5 async reset");
    @(negedge clk);
    key = 1'b1;
    e = 0;
    to_edge(1);
    chk("t5 restart rom_rd", 32'(bus0.rom_rd_o), 32'd1);
    chk("t5 restart rom_addr", 32'(bus0.rom_addr_o), 32'd0);
    to_edge(3);
    chk("t5 restart mem_we", 32'(bus0.mem_we_o), 32'd1);
    chk("t5 restart mem_addr", 32'(bus0.mem_addr_o), 32'd0);
    to_edge(14);
    chk("t5 load_done e14", 32'(ld0), 32'd1);
    chk("t5 checksum", cs0, 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
